// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : Y86-64 pipelined fetch stage with F (predPC + run/stop FSM) and
//            D pipeline registers. Selects the fetch PC, splits the
//            instruction bytes, computes valP / next predPC and fetch status.
// Options  : FETCH_IFUN_CHECK_EN - when defined, ifun is validated per icode
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        bubble_d,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic [79:0] imem_bytes,
  input  logic        imem_error,
  output logic [63:0] f_pc,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic [2:0]  D_stat,
  output logic        fetch_stopped
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_STOP = 1'b1} state_t;

  localparam logic [3:0] c_INOP  = 4'h1;
  localparam logic [3:0] c_RNONE = 4'hF;
  localparam logic [2:0] c_SAOK  = 3'd1;
  localparam logic [2:0] c_SHLT  = 3'd2;
  localparam logic [2:0] c_SADR  = 3'd3;
  localparam logic [2:0] c_SINS  = 3'd4;

  state_t      state_q, state_d;
  logic [63:0] predpc_q, predpc_d;
  logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
  logic [3:0]  icode_d, ifun_d, ra_d, rb_d;
  logic [63:0] valc_q, valp_q, valc_d, valp_d;
  logic [2:0]  stat_q, stat_d;

  logic        w_redirect_m, w_redirect_w, w_redirect, w_fetch_active;
  logic [3:0]  w_icode, w_ifun, w_ra, w_rb, w_len;
  logic [63:0] w_valc, w_valp, w_next_pc;
  logic [2:0]  w_stat;
  logic        w_ifun_bad;

  assign w_redirect_m   = (M_icode == 4'h7) && !M_cnd;
  assign w_redirect_w   = (W_icode == 4'h9);
  assign w_redirect     = w_redirect_m || w_redirect_w;
  assign f_pc           = w_redirect_m ? M_valA : (w_redirect_w ? W_valM : predpc_q);
  // In STOP only an accepted redirect (not lost to stall_f) restarts fetching.
  assign w_fetch_active = (state_q == ST_RUN) || (w_redirect && !stall_f);
  assign w_valp         = f_pc + {60'd0, w_len};

  // Split the instruction bytes and derive length, operands and status.
  always_comb begin
    w_icode    = imem_bytes[7:4];
    w_ifun     = imem_bytes[3:0];
    w_len      = 4'd1;
    w_ra       = c_RNONE;
    w_rb       = c_RNONE;
    w_valc     = 64'd0;
    w_ifun_bad = 1'b0;
    case (w_icode)
      4'h2, 4'h6, 4'hA, 4'hB: begin
        w_len = 4'd2;
        w_ra  = imem_bytes[15:12];
        w_rb  = imem_bytes[11:8];
      end
      4'h3, 4'h4, 4'h5: begin
        w_len  = 4'd10;
        w_ra   = imem_bytes[15:12];
        w_rb   = imem_bytes[11:8];
        w_valc = imem_bytes[79:16];
      end
      4'h7, 4'h8: begin
        w_len  = 4'd9;
        w_valc = imem_bytes[71:8];
      end
      default: w_len = 4'd1;
    endcase
`ifdef FETCH_IFUN_CHECK_EN
    case (w_icode)
      4'h6:       w_ifun_bad = (w_ifun > 4'd3);
      4'h2, 4'h7: w_ifun_bad = (w_ifun > 4'd6);
      default:    w_ifun_bad = (w_ifun != 4'd0);
    endcase
`endif
    if (imem_error)                       w_stat = c_SADR;
    else if (w_icode > 4'hB || w_ifun_bad) w_stat = c_SINS;
    else if (w_icode == 4'h0)             w_stat = c_SHLT;
    else                                  w_stat = c_SAOK;
    if (imem_error)                       w_next_pc = f_pc;
    else if (w_icode == 4'h7 || w_icode == 4'h8) w_next_pc = w_valc;
    else                                  w_next_pc = w_valp;
  end

  // Next predPC / FSM state and D-register contents.
  always_comb begin
    state_d  = state_q;
    predpc_d = predpc_q;
    icode_d  = icode_q;
    ifun_d   = ifun_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    valc_d   = valc_q;
    valp_d   = valp_q;
    stat_d   = stat_q;
    if (!stall_f && w_fetch_active) begin
      predpc_d = w_next_pc;
      state_d  = (w_stat != c_SAOK) ? ST_STOP : ST_RUN;
    end
    if (bubble_d || (!stall_d && !w_fetch_active)) begin
      icode_d = c_INOP;
      ifun_d  = 4'h0;
      ra_d    = c_RNONE;
      rb_d    = c_RNONE;
      valc_d  = 64'd0;
      valp_d  = 64'd0;
      stat_d  = c_SAOK;
    end else if (!stall_d) begin
      if (imem_error) begin
        icode_d = c_INOP;
        ifun_d  = 4'h0;
        ra_d    = c_RNONE;
        rb_d    = c_RNONE;
        valc_d  = 64'd0;
      end else begin
        icode_d = w_icode;
        ifun_d  = w_ifun;
        ra_d    = w_ra;
        rb_d    = w_rb;
        valc_d  = w_valc;
      end
      valp_d = imem_error ? f_pc : w_valp;
      stat_d = w_stat;
    end
  end

  // F register: predicted PC and run/stop state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      predpc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      predpc_q <= predpc_d;
    end
  end

  // D register; resets to the bubble value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icode_q <= c_INOP;
      ifun_q  <= 4'h0;
      ra_q    <= c_RNONE;
      rb_q    <= c_RNONE;
      valc_q  <= 64'd0;
      valp_q  <= 64'd0;
      stat_q  <= c_SAOK;
    end else begin
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      stat_q  <= stat_d;
    end
  end

  assign D_icode       = icode_q;
  assign D_ifun        = ifun_q;
  assign D_rA          = ra_q;
  assign D_rB          = rb_q;
  assign D_valC        = valc_q;
  assign D_valP        = valp_q;
  assign D_stat        = stat_q;
  assign fetch_stopped = (state_q == ST_STOP);

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Pipelined Y86-64 fetch stage with its F and D pipeline registers. It selects the fetch PC from the predicted PC, a mispredicted-jump correction from M, or a `ret` target from W. It splits the 10 instruction bytes into icode/ifun/rA/rB/valC, computes valP and the next predicted PC, and latches the result into the D register. It produces the icode/valC/valP fields that the PC-update logic consumes, and it freezes fetch after a halt or fault until a redirect occurs.

## Interface
- RESET_PC, 64'd0, value loaded into predPC on reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall_f  in  1  hold predPC and the fetch FSM
- stall_d  in  1  hold the D register
- bubble_d  in  1  load a nop bubble into D; has priority over stall_d
- M_icode  in  4  icode in the M stage
- M_cnd  in  1  branch condition in the M stage
- M_valA  in  64  fall-through PC of the jump in M
- W_icode  in  4  icode in the W stage
- W_valM  in  64  return address popped by a `ret` in W
- imem_bytes  in  80  the 10 bytes at f_pc; byte k is at bits [8k+7:8k]
- imem_error  in  1  f_pc address is invalid
- f_pc  out  64  combinational fetch address sent to instruction memory
- D_icode, D_ifun  out  4 each  registered
- D_rA, D_rB  out  4 each  registered; 4'hF means no register
- D_valC, D_valP  out  64 each  registered
- D_stat  out  3  registered; 1 = AOK, 2 = HLT, 3 = ADR, 4 = INS
- fetch_stopped  out  1  FSM is in the STOP state

## Operation
- PC select, in priority order:
  - M_icode == 7 and !M_cnd → M_valA
  - W_icode == 9 → W_valM
  - otherwise predPC
- A redirect is either of the first two cases.
- Decode of byte 0: icode = [7:4], ifun = [3:0].
- Instruction length by icode:
  - 0, 1, 9: 1 byte
  - 2, 6, A, B: 2 bytes
  - 3, 4, 5: 10 bytes
  - 7, 8: 9 bytes
  - any other icode: 1 byte
- Register byte: icodes 2–6, A and B use byte 1 (rA = [7:4], rB = [3:0]). All other icodes give rA = rB = F.
- valC: icodes 3, 4, 5 use bytes 2–9; icodes 7, 8 use bytes 1–8. Both are little-endian. All other icodes give valC = 0.
- valP = f_pc + length, modulo 2^64 (wrap-around is silent).
- Next predPC: valC for icode 7 or 8; valP otherwise.
- Fetched stat, in priority order: imem_error → ADR; icode > B → INS; icode 0 → HLT; otherwise AOK.
- On ADR, D receives icode = 1 (nop) with stat ADR, and next predPC = f_pc.
- FSM states:
  - RUN to STOP: on an update cycle in RUN whose fetched stat is not AOK.
  - STOP to RUN: on any redirect. That cycle fetches normally from the redirect target and can re-enter STOP if the target also faults.
- In STOP with no redirect:
  - predPC is held.
  - D loads a bubble if it is not stalled.
- An update cycle is any cycle with !stall_f. While stall_f = 1, predPC and the FSM hold; f_pc and redirect selection remain live.
- D register, in priority order:
  - bubble_d → icode 1, ifun 0, rA = rB = F, valC = 0, valP = 0, stat AOK
  - stall_d → hold
  - otherwise load the fetched fields

## Timing
- On reset: predPC = RESET_PC, FSM = RUN, D = the bubble value. Outputs therefore reset to D_icode = 1, D_stat = 1, fetch_stopped = 0.
- f_pc is combinational from predPC, M_* and W_* in the same cycle. It has no registered delay.
- Latency: the instruction at f_pc appears on D_* after the next rising edge (1 cycle).
- predPC and the FSM update on the same edge as D.
- Reset asserted mid-instruction clears everything asynchronously. The first fetch after release is from RESET_PC.
- If bubble_d and stall_d are asserted together, the bubble wins. If stall_f and a redirect are asserted together, the stall wins: the redirect is lost unless it is re-presented.

## Configuration
- FETCH_IFUN_CHECK_EN
  - Defined: ifun is also validated. OPq (6) allows ifun 0–3, jXX (7) and cmovXX (2) allow 0–6, and every other icode requires 0. A violation yields stat INS.
  - Undefined: ifun is never checked; only icode > B yields INS.

## Test plan
- Reset with RESET_PC = 0; bytes 30 F2 0A 00 00 00 00 00 00 00 → after 1 edge D_icode = 3, D_rB = 2, D_valC = 10, D_valP = 10, and f_pc = 10.
- jXX at 0x20 with valC = 0x40 → f_pc = 0x40. Later M_icode = 7, M_cnd = 0, M_valA = 0x29 → f_pc = 0x29 in the same cycle.
- W_icode = 9 with W_valM = 0x123 while stall_f = 0 → f_pc = 0x123 and predPC follows valP after 0x123.
- halt (byte 00) fetched → D_stat = 2, fetch_stopped = 1, and the following cycles give D_icode = 1 and a constant f_pc. A redirect to 0x50 → fetch_stopped = 0.
- Byte F0 → D_stat = 4. With the macro on, byte 67 → D_stat = 4; with it off, D_stat = 1.
- stall_d = 1 and bubble_d = 1 in the same cycle → D becomes the bubble. imem_error = 1 → D_stat = 3.
